sqrt_arb: RTL and testbench
===========================

Name: sqrt_arb

Overview:
Shares one sqrt_u32 pipeline between N_REQ requesters. Each requester has a valid/ready request channel and a valid/ready response channel. Per-requester result buffering is reserved by credits, so the non-stallable pipeline never overruns a buffer. The block sits between the client blocks and a sqrt_u32 instance; that instance sits outside this block and shares clk/rst_n with it.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- LATENCY, 15, cycles from core_vld_in to core_vld_out of the attached sqrt_u32
- RSP_DEPTH, 4, response FIFO depth per requester; also the credit limit
- TAG_W, $clog2(N_REQ), requester tag width (derived)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req_vld  in  N_REQ  request valid per requester
- req_rdy  out  N_REQ  request accepted this cycle
- req_x  in  32*N_REQ  operand; requester i uses bits [32i+31:32i]
- rsp_vld  out  N_REQ  result available per requester
- rsp_rdy  in  N_REQ  requester consumes result
- rsp_y  out  16*N_REQ  result; requester i uses bits [16i+15:16i]
- core_vld_in  out  1  issue strobe to sqrt_u32.vld_in
- core_x  out  32  operand to sqrt_u32.x
- core_vld_out  in  1  sqrt_u32.vld_out
- core_y  in  16  sqrt_u32.y
- err_sync  out  1  sticky flag: core output misaligned with the tag pipe

Behaviour:
- Clocking and reset:
  - One clock, clk. rst_n is asynchronous, active-low.
  - Reset values: req_rdy=0, rsp_vld=0, core_vld_in=0, core_x=0, err_sync=0.
  - Reset also clears the round-robin pointer to 0, all credits to 0, all FIFOs to empty, and the tag pipe to invalid.
- Credits:
  - used[i] counts requester i's in-flight operations plus its buffered results (width $clog2(RSP_DEPTH+1)).
  - used[i] +1 on request accept, -1 on response pop; both in the same cycle leaves it unchanged.
  - eligible[i] = req_vld[i] && used[i] < RSP_DEPTH.
- Arbitration:
  - Round-robin, combinational. Search starts at ptr and picks the first eligible index cyclically.
  - req_rdy is one-hot or zero. It may depend on req_vld; requesters must not make req_vld depend on req_rdy.
  - On accept, ptr <= grant+1 (wraps to 0 after N_REQ-1). With no accept, ptr holds.
  - At most one accept per cycle; full throughput is 1 operation/cycle.
- Issue:
  - On accept, at the next edge: core_vld_in<=1 and core_x<=req_x[grant].
  - With no accept: core_vld_in<=0 and core_x holds its value.
  - Accept-to-core latency is 1 cycle.
- Tag pipe:
  - LATENCY-deep shift register of {valid, tag}, loaded alongside core_vld_in.
  - Its tail is aligned with core_vld_out.
  - If tail.valid != core_vld_out, err_sync<=1 and stays 1 until reset. No result is written in that cycle.
- Response:
  - When core_vld_out && tail.valid, core_y is pushed into FIFO[tail.tag].
  - rsp_vld[i] = FIFO[i] non-empty; rsp_y[i] = FIFO[i] head. Pop on rsp_vld[i] && rsp_rdy[i].
  - Push and pop on the same FIFO in the same cycle are both honoured.
  - Overflow is impossible by construction of the credits. The implementation still asserts push-into-full in simulation only.
- Latency: accept edge to rsp_vld = LATENCY+2 cycles (1 issue + LATENCY core + 1 FIFO write).
- Ordering: results return in issue order per requester.
- Reset mid-operation: in-flight work is discarded. The core is reset by the same rst_n, so no stale core_vld_out arrives.

Optional Feature:
SQRT_ARB_STATS_EN:
- Defined: adds output stat_issued, 32*N_REQ bits, and input stat_clr, 1 bit.
  - Per-requester 32-bit accept counters, saturating at 0xFFFFFFFF.
  - stat_clr clears them synchronously; a clear in the same cycle as an accept wins (count becomes 0).
  - Counters reset to 0.
- Undefined: those ports and all counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Package sqrt_arb_pkg holds:
  - SQRT_LATENCY=15, the default for LATENCY
  - SQRT_IN_W=32, SQRT_OUT_W=16
  - typedef tag_entry_t {logic valid; logic [TAG_W-1:0] tag;}
- One sub-module, sqrt_arb_rsp_fifo: a 16-bit synchronous FIFO of depth RSP_DEPTH with push/pop/empty/full/head, instantiated N_REQ times in a generate loop.
- Arbiter, credits and tag pipe stay in the top module.

Test Plan:
- Idle-to-busy, round trip (core attached): req0 x=1000000 accepted -> core_vld_in exactly 1 cycle later; rsp_vld[0]=1 with rsp_y=1000 exactly 17 cycles after accept; x=0 -> 0; x=0xFFFFFFFF -> 65535.
- Fairness, round-robin: all 4 req_vld held high with rsp_rdy=1 -> grants 0,1,2,3,0,1... one per cycle; core_vld_in continuously 1; no err_sync.
- Credit stall: rsp_rdy[1]=0 with req1 streaming -> exactly 4 accepts, then req_rdy[1]=0 while req0/2/3 continue. Raising rsp_rdy[1] -> 4 results (in order) drain, then accepts resume.
- Misalignment detection (core replaced by a model): pulse core_vld_out with the tag pipe empty -> err_sync=1 the next cycle and held; no rsp_vld asserted.
- Reset mid-flight: assert rst_n=0 with 6 operations in flight -> all outputs at reset values immediately. After release, req0 issues at full credit (4 accepts possible) and no stale responses appear.
- Stats, with SQRT_ARB_STATS_EN defined: 10 accepts on req2 -> stat_issued[2]=10. stat_clr in the same cycle as an accept -> counter reads 0.

Source files
------------

// File: rtl/sqrt_arb_pkg.sv
// Shared constants and types for the sqrt_arb pipeline-sharing block.
package sqrt_arb_pkg;

    localparam int SQRT_LATENCY = 15;
    localparam int SQRT_IN_W    = 32;
    localparam int SQRT_OUT_W   = 16;
    // Wide enough for the largest supported requester count (8).
    localparam int PKG_TAG_W    = 3;

    typedef struct packed {
        logic                 valid;
        logic [PKG_TAG_W-1:0] tag;
    } tag_entry_t;

endpackage

// File: rtl/sqrt_arb_rsp_fifo.sv
// Per-requester response buffer (synchronous FIFO) and its overflow checker.
module sqrt_arb_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_empty,
    output logic         o_full,
    output logic [W-1:0] o_head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + AW'(1);
        end
    endfunction

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_head  = r_mem[r_rd];

    // Storage write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
        end else if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= wrap_inc(r_wr);
            if (w_pop)  r_rd <= wrap_inc(r_rd);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

module sqrt_arb_rsp_fifo_chk (
    input logic clk,
    input logic rst_n,
    input logic i_push,
    input logic i_full
);
    // Credits must keep the core from ever writing into a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(i_push && i_full));
endmodule

// File: rtl/sqrt_arb.sv
// Round-robin, credit-controlled sharing of one sqrt_u32 pipeline between N_REQ requesters.
// Optional macro SQRT_ARB_STATS_EN adds per-requester accept counters (stat_issued/stat_clr).
module sqrt_arb
    import sqrt_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int LATENCY   = SQRT_LATENCY,
    parameter int RSP_DEPTH = 4,
    parameter int TAG_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_vld,
    output logic [N_REQ-1:0]            req_rdy,
    input  logic [SQRT_IN_W*N_REQ-1:0]  req_x,
    output logic [N_REQ-1:0]            rsp_vld,
    input  logic [N_REQ-1:0]            rsp_rdy,
    output logic [SQRT_OUT_W*N_REQ-1:0] rsp_y,
    output logic                        core_vld_in,
    output logic [SQRT_IN_W-1:0]        core_x,
    input  logic                        core_vld_out,
    input  logic [SQRT_OUT_W-1:0]       core_y,
    output logic                        err_sync
`ifdef SQRT_ARB_STATS_EN
    ,
    input  logic                        stat_clr,
    output logic [32*N_REQ-1:0]         stat_issued
`endif
);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [CW-1:0]        r_used [N_REQ];
    logic [TAG_W-1:0]     r_ptr;
    logic                 r_core_vld;
    logic [SQRT_IN_W-1:0] r_core_x;
    logic [TAG_W-1:0]     r_issue_tag;
    tag_entry_t           r_pipe [LATENCY];
    logic                 r_err;

    logic [N_REQ-1:0]     w_elig;
    logic [N_REQ-1:0]     w_pop;
    logic [N_REQ-1:0]     w_push;
    logic [N_REQ-1:0]     w_full;
    logic                 w_found;
    logic                 w_accept;
    logic [TAG_W-1:0]     w_grant;
    tag_entry_t           w_tail;

    function automatic logic [TAG_W-1:0] next_idx(input logic [TAG_W-1:0] idx);
        if (idx == TAG_W'(N_REQ - 1)) begin
            return '0;
        end else begin
            return idx + TAG_W'(1);
        end
    endfunction

    assign w_tail      = r_pipe[LATENCY-1];
    assign w_accept    = w_found && rst_n;
    assign core_vld_in = r_core_vld;
    assign core_x      = r_core_x;
    assign err_sync    = r_err;

    // Round-robin search starting at the pointer
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && w_elig[(int'(r_ptr) + k) % N_REQ]) begin
                w_found = 1'b1;
                w_grant = TAG_W'((int'(r_ptr) + k) % N_REQ);
            end else begin
                w_found = w_found;
            end
        end
    end

    // One-hot accept strobe
    always_comb begin
        req_rdy = '0;
        if (w_accept) begin
            req_rdy[w_grant] = 1'b1;
        end else begin
            req_rdy = '0;
        end
    end

    // Round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= next_idx(w_grant);
        end
    end

    // Credit counters: in-flight plus buffered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) r_used[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                case ({req_rdy[i], w_pop[i]})
                    2'b10:   r_used[i] <= r_used[i] + CW'(1);
                    2'b01:   r_used[i] <= r_used[i] - CW'(1);
                    default: r_used[i] <= r_used[i];
                endcase
            end
        end
    end

    // Issue register driving the core
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_vld  <= 1'b0;
            r_core_x    <= '0;
            r_issue_tag <= '0;
        end else if (w_accept) begin
            r_core_vld  <= 1'b1;
            r_core_x    <= req_x[SQRT_IN_W*w_grant +: SQRT_IN_W];
            r_issue_tag <= w_grant;
        end else begin
            r_core_vld  <= 1'b0;
        end
    end

    // Tag pipe mirrors the core so its tail lines up with core_vld_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LATENCY; k++) r_pipe[k] <= '0;
        end else begin
            r_pipe[0] <= '{valid: r_core_vld, tag: PKG_TAG_W'(r_issue_tag)};
            for (int k = 1; k < LATENCY; k++) r_pipe[k] <= r_pipe[k-1];
        end
    end

    // Sticky misalignment flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_tail.valid != core_vld_out) begin
            r_err <= 1'b1;
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        logic w_empty;

        assign w_elig[gi] = req_vld[gi] && (r_used[gi] < CW'(RSP_DEPTH));
        assign w_push[gi] = core_vld_out && w_tail.valid && (w_tail.tag == PKG_TAG_W'(gi));
        assign w_pop[gi]  = rsp_vld[gi] && rsp_rdy[gi];
        assign rsp_vld[gi] = !w_empty;

        sqrt_arb_rsp_fifo #(
            .DEPTH (RSP_DEPTH),
            .W     (SQRT_OUT_W)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[gi]),
            .i_data  (core_y),
            .i_pop   (rsp_rdy[gi]),
            .o_empty (w_empty),
            .o_full  (w_full[gi]),
            .o_head  (rsp_y[SQRT_OUT_W*gi +: SQRT_OUT_W])
        );

        sqrt_arb_rsp_fifo_chk u_chk (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_push (w_push[gi]),
            .i_full (w_full[gi])
        );
    end

`ifdef SQRT_ARB_STATS_EN
    logic [31:0] r_stat [N_REQ];

    // Saturating accept counters; a clear beats a coincident accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) r_stat[i] <= 32'd0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (stat_clr) begin
                    r_stat[i] <= 32'd0;
                end else if (req_rdy[i] && (r_stat[i] != 32'hFFFF_FFFF)) begin
                    r_stat[i] <= r_stat[i] + 32'd1;
                end
            end
        end
    end

    for (genvar gs = 0; gs < N_REQ; gs++) begin : g_stat
        assign stat_issued[32*gs +: 32] = r_stat[gs];
    end
`endif

endmodule

// File: tb/tb_sqrt_arb.sv
// Randomised and directed bench for sqrt_arb with a queue-based reference model and a sqrt core model.
module tb_sqrt_arb;
    localparam int N  = 4;
    localparam int L  = 15;
    localparam int D  = 4;
    localparam int RT = L + 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_vld, req_rdy, rsp_vld, rsp_rdy;
    logic [32*N-1:0] req_x;
    logic [16*N-1:0] rsp_y;
    logic            core_vld_in, core_vld_out, err_sync, inject;
    logic [31:0]     core_x;
    logic [15:0]     core_y;
`ifdef SQRT_ARB_STATS_EN
    logic            stat_clr;
    logic [32*N-1:0] stat_issued;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sqrt_arb #(.N_REQ(N), .LATENCY(L), .RSP_DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_vld      (req_vld),
        .req_rdy      (req_rdy),
        .req_x        (req_x),
        .rsp_vld      (rsp_vld),
        .rsp_rdy      (rsp_rdy),
        .rsp_y        (rsp_y),
        .core_vld_in  (core_vld_in),
        .core_x       (core_x),
        .core_vld_out (core_vld_out),
        .core_y       (core_y),
        .err_sync     (err_sync)
`ifdef SQRT_ARB_STATS_EN
        ,
        .stat_clr     (stat_clr),
        .stat_issued  (stat_issued)
`endif
    );

    function automatic logic [15:0] isqrt(input logic [31:0] x);
        logic [15:0] r;
        logic [31:0] t;
        r = 16'd0;
        for (int b = 15; b >= 0; b--) begin
            t = {16'd0, r | (16'd1 << b)};
            if (t * t <= x) r = t[15:0];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stand-in sqrt_u32: fixed L-cycle delay, shares rst_n; inject forces a stray vld_out
    logic [L-1:0] cm_vld;
    logic [15:0]  cm_y [L];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cm_vld <= '0;
            for (int k = 0; k < L; k++) cm_y[k] <= 16'd0;
        end else begin
            cm_vld  <= {cm_vld[L-2:0], core_vld_in};
            cm_y[0] <= isqrt(core_x);
            for (int k = 1; k < L; k++) cm_y[k] <= cm_y[k-1];
        end
    end
    assign core_vld_out = cm_vld[L-1] | inject;
    assign core_y       = cm_y[L-1];

    // Reference model: in-flight list with due cycles, per-requester result queues
    typedef struct { int req; logic [15:0] y; int due; } item_t;
    item_t       infl [$];
    logic [15:0] mbuf [N][$];
    int          mptr, cyc;
    logic        m_core_vld, m_err;
    logic [31:0] m_core_x;
    logic [31:0] mstat [N];

    task automatic model_clear();
        infl.delete();
        for (int i = 0; i < N; i++) begin
            mbuf[i].delete();
            mstat[i] = 32'd0;
        end
        mptr = 0; m_core_vld = 1'b0; m_core_x = 32'd0; m_err = 1'b0;
    endtask

    initial begin : compare
        int used [N];
        int g;
        logic [N-1:0] exp_rdy;
        logic arrives;
        model_clear();
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                model_clear();
            end else begin
                for (int i = 0; i < N; i++) used[i] = mbuf[i].size();
                foreach (infl[j]) used[infl[j].req]++;
                g = -1;
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_vld[(mptr + k) % N] && used[(mptr + k) % N] < D) g = (mptr + k) % N;
                end
                exp_rdy = '0;
                if (g >= 0) exp_rdy[g] = 1'b1;
                chk("req_rdy", req_rdy, exp_rdy);
                for (int i = 0; i < N; i++) begin
                    chk("rsp_vld", rsp_vld[i], mbuf[i].size() > 0);
                    if (mbuf[i].size() > 0) chk("rsp_y", rsp_y[16*i +: 16], mbuf[i][0]);
`ifdef SQRT_ARB_STATS_EN
                    chk("stat_issued", stat_issued[32*i +: 32], mstat[i]);
`endif
                end
                chk("core_vld_in", core_vld_in, m_core_vld);
                chk("core_x", core_x, m_core_x);
                chk("err_sync", err_sync, m_err);
                // advance model to next cycle
                arrives = 1'b0;
                foreach (infl[j]) if (infl[j].due == cyc + 1) arrives = 1'b1;
                if (inject && !arrives) m_err = 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (mbuf[i].size() > 0 && rsp_rdy[i]) void'(mbuf[i].pop_front());
`ifdef SQRT_ARB_STATS_EN
                    if (stat_clr) mstat[i] = 32'd0;
                    else if (g == i && mstat[i] != 32'hFFFF_FFFF) mstat[i] = mstat[i] + 32'd1;
`endif
                end
                if (g >= 0) begin
                    infl.push_back('{g, isqrt(req_x[32*g +: 32]), cyc + RT});
                    mptr = (g + 1) % N;
                    m_core_vld = 1'b1;
                    m_core_x = req_x[32*g +: 32];
                end else begin
                    m_core_vld = 1'b0;
                end
                while (infl.size() > 0 && infl[0].due == cyc + 1) begin
                    mbuf[infl[0].req].push_back(infl[0].y);
                    void'(infl.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, cnt, others;
        logic seen, stale;
        logic [N-1:0] one;
        one = 1;
        rst_n = 1'b1; req_vld = '0; req_x = '0; rsp_rdy = '0; inject = 1'b0;
`ifdef SQRT_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req_rdy", req_rdy, 4'h0);
        chk("rst_rsp_vld", rsp_vld, 4'h0);
        chk("rst_core_vld", core_vld_in, 1'b0);
        chk("rst_core_x", core_x, 32'h0);
        chk("rst_err", err_sync, 1'b0);
        chk("pin_isqrt_1e6", isqrt(32'd1000000), 16'd1000);
        chk("pin_isqrt_0", isqrt(32'd0), 16'd0);
        chk("pin_isqrt_max", isqrt(32'hFFFF_FFFF), 16'd65535);
        chk("pin_isqrt_15", isqrt(32'd15), 16'd3);
        repeat (3) step();
        rst_n = 1'b1;

        // round trip latency
        rsp_rdy = '1; req_x[31:0] = 32'd1000000; req_vld = 4'b0001;
        @(negedge clk);
        chk("rt_accept", req_rdy, 4'b0001);
        step();
        req_vld = '0;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("rt_issue", core_vld_in, 1'b1);
            if (rsp_vld[0]) begin
                seen = 1'b1;
                chk("rt_y", rsp_y[15:0], 16'd1000);
            end
        end
        chk("rt_latency", n, RT);

        // boundary operands, buffered then popped in order
        step();
        rsp_rdy = 4'b1110; req_x[31:0] = 32'd0; req_vld = 4'b0001;
        step();
        req_x[31:0] = 32'hFFFF_FFFF;
        step();
        req_vld = '0;
        repeat (RT + 2) step();
        @(negedge clk);
        chk("sp_zero_vld", rsp_vld[0], 1'b1);
        chk("sp_zero", rsp_y[15:0], 16'd0);
        step();
        rsp_rdy = '1;
        step();
        @(negedge clk);
        chk("sp_max", rsp_y[15:0], 16'd65535);
        repeat (RT + 4) step();

        // round-robin fairness from ptr=1
        req_vld = '1; rsp_rdy = '1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("rr_grant", req_rdy, one << ((1 + k) % N));
            if (k > 0) chk("rr_busy", core_vld_in, 1'b1);
            step();
        end
        req_vld = '0;
        repeat (RT + 4) step();

        // credit stall on requester 1
        rsp_rdy = 4'b1101; req_vld = '1; cnt = 0; others = 0;
        repeat (40) begin
            @(negedge clk);
            if (req_rdy[1]) cnt++;
            if ((req_rdy & 4'b1101) != 4'b0000) others++;
            step();
        end
        chk("cr_accepts", cnt, 4);
        chk("cr_others", others >= 16, 1'b1);
        rsp_rdy = '1; cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (req_rdy[1]) cnt++;
            step();
        end
        chk("cr_resume", cnt > 0, 1'b1);
        req_vld = '0;
        repeat (RT + 4) step();

        // randomised traffic
        repeat (800) begin
            req_vld = N'($urandom);
            rsp_rdy = ($urandom_range(2) == 0) ? '1 : N'($urandom);
            for (int i = 0; i < N; i++)
                req_x[32*i +: 32] = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
`ifdef SQRT_ARB_STATS_EN
            stat_clr = ($urandom_range(39) == 0);
`endif
            step();
        end
        req_vld = '0; rsp_rdy = '1;
`ifdef SQRT_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (RT + 6) step();

        // stray core_vld_out with an empty tag pipe
        inject = 1'b1;
        step();
        inject = 1'b0;
        @(negedge clk);
        chk("ms_err", err_sync, 1'b1);
        chk("ms_no_rsp", rsp_vld, 4'h0);
        repeat (5) step();
        @(negedge clk);
        chk("ms_err_held", err_sync, 1'b1);
        step();

        // reset with work in flight
        rsp_rdy = '0; req_vld = '1;
        repeat (6) step();
        req_vld = '1;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("rs_req_rdy", req_rdy, 4'h0);
        chk("rs_rsp_vld", rsp_vld, 4'h0);
        chk("rs_core_vld", core_vld_in, 1'b0);
        chk("rs_core_x", core_x, 32'h0);
        chk("rs_err", err_sync, 1'b0);
        step();
        step();
        req_vld = 4'b0001; rsp_rdy = '0; rst_n = 1'b1;
        cnt = 0; stale = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (req_rdy[0]) cnt++;
            if (rsp_vld[3:1] != 3'b000) stale = 1'b1;
            step();
        end
        chk("rs_accepts", cnt, 4);
        chk("rs_stale", stale, 1'b0);
        req_vld = '0; rsp_rdy = '1;
        repeat (RT + 4) step();

`ifdef SQRT_ARB_STATS_EN
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0; req_vld = 4'b0100; cnt = 0; n = 0;
        while (cnt < 10 && n < 200) begin
            @(negedge clk);
            if (req_rdy[2]) cnt++;
            n++;
            step();
        end
        req_vld = '0;
        chk("st_count_done", cnt, 10);
        @(negedge clk);
        chk("st_ten", stat_issued[95:64], 32'd10);
        repeat (RT + 4) step();
        req_vld = 4'b0100; stat_clr = 1'b1;
        @(negedge clk);
        chk("st_clr_accept", req_rdy, 4'b0100);
        step();
        req_vld = '0; stat_clr = 1'b0;
        @(negedge clk);
        chk("st_clr_wins", stat_issued[95:64], 32'd0);
        repeat (RT + 4) step();
`endif

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
